scan_mux_n_to_1: RTL
====================

# scan_mux_n_to_1

Parametrised, clocked successor to the dual 4-to-1 multiplexer: CH independent channels, each selecting one of N W-bit inputs, with per-channel active-low strobes and registered outputs. A built-in scan timer steps the select automatically and drives active-low one-hot digit enables. It sits between the clock's BCD counters and the seven-segment decoder, and replaces the separate select counter plus mux pair.

## Interface
- W, 4: data width per input.
- N, 4: inputs per channel. Power of two, ≥2. SW = $clog2(N).
- CH, 2: number of channels.
- DIV, 1000: clk cycles per scan slot. Must be ≥2.
- BLANK, 2: blanking cycles at the start of each slot (only with SCAN_BLANK_EN). Must satisfy 1 ≤ BLANK < DIV.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = manual select, 1 = auto scan.
- sel  in  SW  manual select, used when mode=0.
- s_n  in  CH  per-channel strobe, active low; 1 forces that channel's y to 0.
- d  in  CH*N*W  flattened inputs; channel c, input i at d[(c*N+i)*W +: W].
- y  out  CH*W  registered outputs; channel c at y[c*W +: W].
- slot  out  SW  current select value (internal register).
- dig_n  out  N  registered active-low one-hot enable of the displayed slot.
- wrap  out  1  one-cycle pulse when auto scan wraps slot N-1 → 0.

## Operation
- Reset (async assert, sync release): slot=0, prescaler=0, y=0, dig_n=all ones, wrap=0.
- Prescaler counts 0..DIV-1 in auto mode; held at 0 in manual mode.
- Auto mode:
  - When prescaler=DIV-1, prescaler→0 and slot→(slot+1) mod N.
  - wrap=1 for exactly the cycle following the N-1→0 transition; otherwise 0.
- Manual mode: slot←sel every cycle; wrap=0.
- Mode changes:
  - auto→manual: slot takes sel on the next edge.
  - manual→auto: prescaler starts from 0 and slot advances from its current value; the first slot therefore lasts a full DIV cycles.
- Output path, every edge, each channel c:
  - y_c ← s_n[c] ? 0 : d[c][slot].
  - dig_n ← ~(1 << slot).
  - Strobes do not affect dig_n.
- Inputs are sampled; there is no combinational path from inputs to outputs.

## Timing
- Latency: 1 cycle from d, s_n, or slot to y and dig_n. y and dig_n always correspond to the same slot.
- Manual sel to y: 2 cycles (sel→slot, slot→y).
- slot is visible 1 cycle before the dig_n/y that reflect it.
- Reset mid-scan: all outputs return to reset values immediately. The scan restarts at slot 0 with a full DIV count.
- sel is never out of range, because N is a power of two.

## Configuration
- SCAN_BLANK_EN defined: in auto mode, while prescaler < BLANK, dig_n=all ones and y=0 (anti-ghosting gap at each slot start, including the first slot after reset). Manual mode is never blanked.
- SCAN_BLANK_EN undefined: no blanking. The BLANK parameter is ignored and outputs switch directly between slots.

## Structure
- Package scan_mux_pkg holds:
  - mode encoding constants MODE_MANUAL=1'b0 and MODE_AUTO=1'b1;
  - default parameter constants;
  - the dig_n one-hot function.
- Sub-module scan_timer contains the prescaler, slot register, and wrap generator, and exports prescaler<BLANK as a blank flag.
- Top level contains the registered mux array, built with a generate loop over CH.

## Test plan
- Reset with W=4, N=4, CH=2, DIV=4: hold rst_n=0 with d random → y=0, dig_n=4'b1111, slot=0, wrap=0; deassert → slot stays 0 for 4 cycles.
- Auto scan, DIV=4, d ch0 = {3,2,1,0}: slot sequence 0,1,2,3,0 each lasting 4 cycles; dig_n 1110,1101,1011,0111 one cycle after slot; wrap pulses once per 16 cycles.
- Manual mode, sel=2, ch1 inputs {4'hD,4'hC,4'hB,4'hA} (index 3..0): y ch1=4'hC two cycles after sel applied; sel=3 then gives 4'hD; wrap stays 0.
- Strobe: s_n=2'b01 in manual mode → y ch0=0, ch1 follows input, dig_n unaffected; release s_n[0] → ch0 valid after 1 cycle.
- Async reset asserted mid-slot (slot=2, prescaler=1) → outputs cleared without a clock edge; after release the scan restarts at slot 0.
- SCAN_BLANK_EN with BLANK=2, DIV=4: first 2 cycles of each auto slot give dig_n=1111 and y=0; manual mode shows no blanking.

Source files
------------

// File: rtl/scan_mux_n_to_1_pkg.sv
// scan_mux_pkg: mode encodings, default parameters and digit-enable helper for scan_mux_n_to_1
package scan_mux_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;
    localparam int DEF_W     = 4;
    localparam int DEF_N     = 4;
    localparam int DEF_CH    = 2;
    localparam int DEF_DIV   = 1000;
    localparam int DEF_BLANK = 2;
    // One bit of the active-low one-hot digit enable: low only at the selected position
    function automatic logic dig_bit_n(input int unsigned slot, input int unsigned pos);
        return slot != pos;
    endfunction
endpackage

// File: rtl/scan_mux_n_to_1_timer.sv
// scan_timer: prescaler, slot register and wrap pulse for scan_mux_n_to_1
module scan_timer
    import scan_mux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    output logic [SW-1:0] slot,
    output logic          wrap,
    output logic          blank
);
    localparam int PW = $clog2(DIV);
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_slot;
    logic          r_wrap;
    logic          w_step;
    assign w_step = r_presc == PW'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= '0;
            r_wrap  <= 1'b0;
        end else if (mode == MODE_MANUAL) begin
            r_presc <= '0;
            r_slot  <= sel;
            r_wrap  <= 1'b0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + PW'(1);
            r_slot  <= r_slot + SW'(w_step);
            r_wrap  <= w_step && (r_slot == SW'(N - 1));
        end
    end
    assign slot  = r_slot;
    assign wrap  = r_wrap;
    assign blank = r_presc < PW'(BLANK);
endmodule

// File: rtl/scan_mux_n_to_1.sv
// scan_mux_n_to_1: CH-channel N:1 registered mux with auto-scan digit drive.
// Define SCAN_BLANK_EN to blank outputs for BLANK cycles at the start of each auto slot.
module scan_mux_n_to_1
    import scan_mux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    parameter int CH    = DEF_CH,
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK,
    parameter int SW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [CH-1:0]     s_n,
    input  logic [CH*N*W-1:0] d,
    output logic [CH*W-1:0]   y,
    output logic [SW-1:0]     slot,
    output logic [N-1:0]      dig_n,
    output logic              wrap
);
`ifdef SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    logic         w_timer_blank;
    logic         w_blank;
    logic [N-1:0] w_dig_n;
    logic [N-1:0] r_dig_n;
    scan_timer #(.N(N), .DIV(DIV), .BLANK(BLANK), .SW(SW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .slot  (slot),
        .wrap  (wrap),
        .blank (w_timer_blank)
    );
    // Manual mode is never blanked
    assign w_blank = BLANK_EN && (mode == MODE_AUTO) && w_timer_blank;
    for (genvar i = 0; i < N; i++) begin : g_dig
        assign w_dig_n[i] = dig_bit_n(32'(slot), i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dig_n <= '1;
        else        r_dig_n <= w_blank ? '1 : w_dig_n;
    end
    assign dig_n = r_dig_n;
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] w_in [N];
        logic [W-1:0] r_y;
        for (genvar i = 0; i < N; i++) begin : g_in
            assign w_in[i] = d[(c*N+i)*W +: W];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_y <= '0;
            else        r_y <= (s_n[c] || w_blank) ? '0 : w_in[slot];
        end
        assign y[c*W +: W] = r_y;
    end
endmodule
